// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU master port among CLIENTS_N clients.
// Define ALU_ARB_TIMEOUT_EN to enable the 255-cycle no-ack grant timeout.
module alu_arbiter #(
  parameter int CLIENTS_N = 4,
  parameter int CLIENTS_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CLIENTS_N-1:0]    client_cycle,
  input  logic [CLIENTS_N-1:0]    client_strobe,
  output logic [CLIENTS_N-1:0]    client_ack,
  output logic [CLIENTS_N-1:0]    client_stall,
  output logic [CLIENTS_N-1:0]    client_err,
  input  logic [9*CLIENTS_N-1:0]  client_op,
  input  logic [18*CLIENTS_N-1:0] client_al,
  input  logic [18*CLIENTS_N-1:0] client_bl,
  input  logic [18*CLIENTS_N-1:0] client_ar,
  input  logic [18*CLIENTS_N-1:0] client_br,
  input  logic [48*CLIENTS_N-1:0] client_cl,
  input  logic [48*CLIENTS_N-1:0] client_cr,
  output logic [47:0]             client_pl,
  output logic [47:0]             client_pr,
  output logic                    alu_cycle,
  output logic                    alu_strobe,
  output logic [8:0]              alu_op,
  output logic [17:0]             alu_al,
  output logic [17:0]             alu_bl,
  output logic [17:0]             alu_ar,
  output logic [17:0]             alu_br,
  output logic [47:0]             alu_cl,
  output logic [47:0]             alu_cr,
  input  logic                    alu_ack,
  input  logic                    alu_stall,
  input  logic [47:0]             alu_pl,
  input  logic [47:0]             alu_pr
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  localparam logic [CLIENTS_W-1:0] GNT_ONE = CLIENTS_W'(1);
  localparam logic [CLIENTS_W-1:0] GNT_MAX = CLIENTS_W'(CLIENTS_N - 1);

  state_t               r_state, w_state_nxt;
  logic [CLIENTS_W-1:0] r_gnt, w_gnt_nxt;
  logic [CLIENTS_W-1:0] r_last, w_last_nxt;
  logic [CLIENTS_W-1:0] w_pick, w_idx;
  logic                 w_pick_vld;
  logic [CLIENTS_N-1:0] w_req;
  logic                 w_own_cyc;
  logic                 w_timeout;

  assign w_own_cyc = client_cycle[r_gnt];
  assign client_pl = alu_pl;
  assign client_pr = alu_pr;

`ifdef ALU_ARB_TIMEOUT_EN
  logic [7:0]           r_cnt;
  logic [CLIENTS_N-1:0] r_block;

  // A timed-out client stays masked until it has dropped its cycle once.
  assign w_req     = client_cycle & ~r_block;
  assign w_timeout = (r_state == ST_GRANT) && w_own_cyc && (r_cnt == 8'hFF) && !alu_ack;

  // No-ack cycle counter and per-client re-grant block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 8'd0;
      r_block <= {CLIENTS_N{1'b0}};
    end else begin
      if ((r_state != ST_GRANT) || alu_ack) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      for (int i = 0; i < CLIENTS_N; i++) begin
        if (w_timeout && (r_gnt == CLIENTS_W'(i))) begin
          r_block[i] <= 1'b1;
        end else if (!client_cycle[i]) begin
          r_block[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign w_req     = client_cycle;
  assign w_timeout = 1'b0;
`endif

  // Round-robin search starting one past the last-served client.
  always_comb begin
    w_pick     = r_last;
    w_pick_vld = 1'b0;
    w_idx      = r_last;
    for (int k = 0; k < CLIENTS_N; k++) begin
      if (w_idx == GNT_MAX) begin
        w_idx = {CLIENTS_W{1'b0}};
      end else begin
        w_idx = w_idx + GNT_ONE;
      end
      if (!w_pick_vld && w_req[w_idx]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_idx;
      end else begin
        w_pick_vld = w_pick_vld;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = w_pick;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!w_own_cyc || w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_gnt;
        end else begin
          w_state_nxt = ST_GRANT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant and last-served registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= {CLIENTS_W{1'b0}};
      r_last  <= GNT_MAX;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // ALU port mux and per-client response routing; an ack after the owner dropped cycle is discarded.
  always_comb begin
    alu_cycle    = 1'b0;
    alu_strobe   = 1'b0;
    alu_op       = 9'd0;
    alu_al       = 18'd0;
    alu_bl       = 18'd0;
    alu_ar       = 18'd0;
    alu_br       = 18'd0;
    alu_cl       = 48'd0;
    alu_cr       = 48'd0;
    client_ack   = {CLIENTS_N{1'b0}};
    client_stall = {CLIENTS_N{1'b1}};
    client_err   = {CLIENTS_N{1'b0}};
    if (r_state == ST_GRANT) begin
      for (int i = 0; i < CLIENTS_N; i++) begin
        if (r_gnt == CLIENTS_W'(i)) begin
          alu_cycle       = client_cycle[i];
          alu_strobe      = client_strobe[i];
          alu_op          = client_op[i*9 +: 9];
          alu_al          = client_al[i*18 +: 18];
          alu_bl          = client_bl[i*18 +: 18];
          alu_ar          = client_ar[i*18 +: 18];
          alu_br          = client_br[i*18 +: 18];
          alu_cl          = client_cl[i*48 +: 48];
          alu_cr          = client_cr[i*48 +: 48];
          client_ack[i]   = alu_ack & client_cycle[i];
          client_stall[i] = alu_stall;
          client_err[i]   = w_timeout;
        end else begin
          client_ack[i]   = 1'b0;
        end
      end
    end else begin
      alu_cycle = 1'b0;
    end
  end

endmodule
